// File: rtl/pkt_ctrl_pkg.sv
// Shared types and default header values for the packet-framing controller.
package pkt_ctrl_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      CHK     = 2'd2
   } st_t;

   localparam logic [7:0] DEF_HDR_A = 8'hA5;
   localparam logic [7:0] DEF_HDR_B = 8'hC3;

endpackage

// File: rtl/serial_byte_det.sv
// Byte-complete detector: one-cycle pulse on the falling edge of the shift enable.
module serial_byte_det (
   input  logic clk,
   input  logic reset,
   input  logic serial_en,
   output logic byte_cmp
);

   logic r_en_q;

   always_ff @(posedge clk) begin
      if (reset) r_en_q <= 1'b0;
      else       r_en_q <= serial_en;
   end

   assign byte_cmp = r_en_q & ~serial_en;

endmodule

// File: rtl/pkt_ctrl.sv
// Packet-framing controller: header hunt, payload counting, registered FIFO writes.
// Optional trailing checksum check is enabled by defining PKT_CHKSUM_EN.
module pkt_ctrl
   import pkt_ctrl_pkg::*;
#(
   parameter int         PAYLOAD_BYTES = 4,
   parameter logic [7:0] HDR_A         = DEF_HDR_A,
   parameter logic [7:0] HDR_B         = DEF_HDR_B
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       serial_en,
   input  logic [7:0] rx_byte,
   input  logic       fifo_full,
   output logic       write,
   output logic [7:0] wr_data,
   output logic       pkt_type,
   output logic       pkt_done,
   output logic       ovf,
   output logic       chk_err
);

   localparam int            CW   = $clog2(PAYLOAD_BYTES + 1);
   localparam logic [CW-1:0] LAST = CW'(PAYLOAD_BYTES - 1);

   st_t           r_state, w_nxt_state;
   logic [CW-1:0] r_cnt, w_nxt_cnt;
   logic          w_byte_cmp, w_is_hdr;
   logic          w_wr, w_ovf, w_done, w_ld_type;
   logic          r_write, r_ovf, r_done, r_pkt_type;
   logic [7:0]    r_wr_data;

   serial_byte_det u_det (
      .clk       (clk),
      .reset     (reset),
      .serial_en (serial_en),
      .byte_cmp  (w_byte_cmp)
   );

   assign w_is_hdr = (rx_byte == HDR_A) || (rx_byte == HDR_B);

`ifdef PKT_CHKSUM_EN
   logic [7:0] r_sum;
   logic       w_err, r_chk_err;

   // Running sum covers header and every payload byte, dropped ones included.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sum <= 8'h00;
      end else if (w_byte_cmp) begin
         if (r_state == HUNT && w_is_hdr) r_sum <= rx_byte;
         else if (r_state == PAYLOAD)     r_sum <= r_sum + rx_byte;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= HUNT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_wr        = 1'b0;
      w_ovf       = 1'b0;
      w_done      = 1'b0;
      w_ld_type   = 1'b0;
`ifdef PKT_CHKSUM_EN
      w_err       = 1'b0;
`endif
      case (r_state)
         HUNT: begin
            if (w_byte_cmp && w_is_hdr) begin
               w_ld_type   = 1'b1;
               w_nxt_cnt   = '0;
               w_nxt_state = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (w_byte_cmp) begin
               w_wr  = ~fifo_full;
               w_ovf = fifo_full;
               if (r_cnt == LAST) begin
                  w_nxt_cnt   = '0;
`ifdef PKT_CHKSUM_EN
                  w_nxt_state = CHK;
`else
                  w_nxt_state = HUNT;
                  w_done      = 1'b1;
`endif
               end else begin
                  w_nxt_cnt = r_cnt + CW'(1);
               end
            end
         end
`ifdef PKT_CHKSUM_EN
         CHK: begin
            if (w_byte_cmp) begin
               w_err       = (rx_byte != r_sum);
               w_done      = 1'b1;
               w_nxt_state = HUNT;
            end
         end
`endif
         default: w_nxt_state = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_write    <= 1'b0;
         r_ovf      <= 1'b0;
         r_done     <= 1'b0;
         r_wr_data  <= 8'h00;
         r_pkt_type <= 1'b0;
      end else begin
         r_write <= w_wr;
         r_ovf   <= w_ovf;
         r_done  <= w_done;
         if (w_wr)      r_wr_data  <= rx_byte;
         if (w_ld_type) r_pkt_type <= (rx_byte == HDR_B);
      end
   end

`ifdef PKT_CHKSUM_EN
   always_ff @(posedge clk) begin
      if (reset) r_chk_err <= 1'b0;
      else       r_chk_err <= w_err;
   end
   assign chk_err = r_chk_err;
`else
   assign chk_err = 1'b0;
`endif

   assign write    = r_write;
   assign wr_data  = r_wr_data;
   assign ovf      = r_ovf;
   assign pkt_done = r_done;
   assign pkt_type = r_pkt_type;

endmodule

// File: tb/tb_pkt_ctrl.sv
// Directed bench for pkt_ctrl: 4-byte and 8-byte payload instances on a shared byte stream.
module tb_pkt_ctrl;

`ifdef PKT_CHKSUM_EN
   localparam bit CHKM = 1'b1;
`else
   localparam bit CHKM = 1'b0;
`endif
   localparam bit LD = !CHKM;  // pkt_done on last payload byte only without checksum

   logic       clk = 1'b0;
   logic       reset, serial_en, fifo_full;
   logic [7:0] rx_byte;
   logic       write, pkt_type, pkt_done, ovf, chk_err;
   logic [7:0] wr_data;
   logic       write8, pkt_type8, pkt_done8, ovf8, chk_err8;
   logic [7:0] wr_data8;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   pkt_ctrl #(.PAYLOAD_BYTES(4)) u_dut (
      .clk(clk), .reset(reset), .serial_en(serial_en), .rx_byte(rx_byte),
      .fifo_full(fifo_full), .write(write), .wr_data(wr_data), .pkt_type(pkt_type),
      .pkt_done(pkt_done), .ovf(ovf), .chk_err(chk_err)
   );

   pkt_ctrl #(.PAYLOAD_BYTES(8)) u_dut8 (
      .clk(clk), .reset(reset), .serial_en(serial_en), .rx_byte(rx_byte),
      .fifo_full(fifo_full), .write(write8), .wr_data(wr_data8), .pkt_type(pkt_type8),
      .pkt_done(pkt_done8), .ovf(ovf8), .chk_err(chk_err8)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Two-cycle byte: serial_en high one cycle, then the fall; returns in cycle N+1.
   task automatic send_byte(input logic [7:0] b, input logic full);
      serial_en = 1'b1;
      rx_byte   = b;
      fifo_full = 1'b0;
      @(posedge clk); #1;
      serial_en = 1'b0;
      fifo_full = full;
      @(posedge clk); #1;
      fifo_full = 1'b0;
   endtask

   task automatic exp4(input string tag, input logic w, input logic [7:0] d,
                       input logic o, input logic dn, input logic t);
      chk({tag, ".write"},    8'(write),    8'(w));
      chk({tag, ".wr_data"},  wr_data,      d);
      chk({tag, ".ovf"},      8'(ovf),      8'(o));
      chk({tag, ".pkt_done"}, 8'(pkt_done), 8'(dn));
      chk({tag, ".pkt_type"}, 8'(pkt_type), 8'(t));
      chk({tag, ".chk_err"},  8'(chk_err),  8'h00);
   endtask

   task automatic exp8(input string tag, input logic w, input logic [7:0] d, input logic dn);
      chk({tag, ".write8"},    8'(write8),    8'(w));
      chk({tag, ".wr_data8"},  wr_data8,      d);
      chk({tag, ".ovf8"},      8'(ovf8),      8'h00);
      chk({tag, ".pkt_done8"}, 8'(pkt_done8), 8'(dn));
      chk({tag, ".pkt_type8"}, 8'(pkt_type8), 8'h01);
   endtask

   // Trailing checksum byte (checksum build only): never written, closes the packet.
   task automatic end_pkt(input string tag, input logic [7:0] sum, input logic [7:0] d,
                          input logic t);
      if (CHKM) begin
         send_byte(sum, 1'b0);
         exp4({tag, ".cks"}, 1'b0, d, 1'b0, 1'b1, t);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      serial_en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; serial_en = 1'b0; fifo_full = 1'b0; rx_byte = 8'h00;
      do_reset();
      exp4("rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Type-0 packet
      send_byte(8'hA5, 1'b0); exp4("t1.hdr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      send_byte(8'h11, 1'b0); exp4("t1.b1",  1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      send_byte(8'h22, 1'b0); exp4("t1.b2",  1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      send_byte(8'h33, 1'b0); exp4("t1.b3",  1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      send_byte(8'h44, 1'b0); exp4("t1.b4",  1'b1, 8'h44, 1'b0, LD,   1'b0);
      end_pkt("t1", 8'h4F, 8'h44, 1'b0);
      @(posedge clk); #1;
      exp4("t1.idle", 1'b0, 8'h44, 1'b0, 1'b0, 1'b0);

      // Non-header bytes ignored, then type-1 packet
      send_byte(8'h00, 1'b0); exp4("t2.ign0", 1'b0, 8'h44, 1'b0, 1'b0, 1'b0);
      send_byte(8'h7F, 1'b0); exp4("t2.ign1", 1'b0, 8'h44, 1'b0, 1'b0, 1'b0);
      send_byte(8'hC3, 1'b0); exp4("t2.hdr",  1'b0, 8'h44, 1'b0, 1'b0, 1'b1);
      send_byte(8'h01, 1'b0); exp4("t2.b1",   1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
      send_byte(8'h02, 1'b0); exp4("t2.b2",   1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
      send_byte(8'h03, 1'b0); exp4("t2.b3",   1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
      send_byte(8'h04, 1'b0); exp4("t2.b4",   1'b1, 8'h04, 1'b0, LD,   1'b1);
      end_pkt("t2", 8'hCD, 8'h04, 1'b1);

      // FIFO full on third payload byte: dropped, ovf, packet still completes
      send_byte(8'hA5, 1'b0); exp4("t3.hdr", 1'b0, 8'h04, 1'b0, 1'b0, 1'b0);
      send_byte(8'h01, 1'b0); exp4("t3.b1",  1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      send_byte(8'h02, 1'b0); exp4("t3.b2",  1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
      send_byte(8'h03, 1'b1); exp4("t3.b3",  1'b0, 8'h02, 1'b1, 1'b0, 1'b0);
      send_byte(8'h04, 1'b0); exp4("t3.b4",  1'b1, 8'h04, 1'b0, LD,   1'b0);
      end_pkt("t3", 8'hAF, 8'h04, 1'b0);

      // Reset mid-packet discards the partial packet
      send_byte(8'hA5, 1'b0); exp4("t4.hdr", 1'b0, 8'h04, 1'b0, 1'b0, 1'b0);
      send_byte(8'h10, 1'b0); exp4("t4.b1",  1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
      send_byte(8'h20, 1'b0); exp4("t4.b2",  1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
      do_reset();
      exp4("t4.rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      send_byte(8'h30, 1'b0); exp4("t4.ign", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      send_byte(8'hA5, 1'b0); exp4("t4.hdr2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      send_byte(8'hAA, 1'b0); exp4("t4.b1x", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      send_byte(8'hBB, 1'b0); exp4("t4.b2x", 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
      send_byte(8'hCC, 1'b0); exp4("t4.b3x", 1'b1, 8'hCC, 1'b0, 1'b0, 1'b0);
      send_byte(8'hDD, 1'b0); exp4("t4.b4x", 1'b1, 8'hDD, 1'b0, LD,   1'b0);
      end_pkt("t4", 8'hB3, 8'hDD, 1'b0);

      // Header-valued bytes inside the payload are plain payload
      send_byte(8'hC3, 1'b0); exp4("t5.hdr", 1'b0, 8'hDD, 1'b0, 1'b0, 1'b1);
      send_byte(8'hA5, 1'b0); exp4("t5.b1",  1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
      send_byte(8'hC3, 1'b0); exp4("t5.b2",  1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
      send_byte(8'h01, 1'b0); exp4("t5.b3",  1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
      send_byte(8'h02, 1'b0); exp4("t5.b4",  1'b1, 8'h02, 1'b0, LD,   1'b1);
      end_pkt("t5", 8'h2E, 8'h02, 1'b1);

      if (CHKM) begin
         // Bad checksum: error strobe with pkt_done, checksum byte never written
         send_byte(8'hA5, 1'b0); exp4("t5c.hdr", 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
         send_byte(8'h01, 1'b0); exp4("t5c.b1",  1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
         send_byte(8'h02, 1'b0); exp4("t5c.b2",  1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
         send_byte(8'h03, 1'b0); exp4("t5c.b3",  1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
         send_byte(8'h04, 1'b0); exp4("t5c.b4",  1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
         send_byte(8'h00, 1'b0);
         chk("t5c.chk_err",  8'(chk_err),  8'h01);
         chk("t5c.pkt_done", 8'(pkt_done), 8'h01);
         chk("t5c.write",    8'(write),    8'h00);
         chk("t5c.wr_data",  wr_data,      8'h04);
      end

      // 8-byte instance at minimum 2-cycle byte spacing
      do_reset();
      send_byte(8'hC3, 1'b0);
      chk("t6.hdr.write8", 8'(write8), 8'h00);
      for (int i = 1; i <= 8; i++) begin
         send_byte(8'(i * 16 + i), 1'b0);
         exp8($sformatf("t6.b%0d", i), 1'b1, 8'(i * 16 + i), (i == 8) && LD);
      end
      if (CHKM) begin
         // 0xC3 + 0x11+0x22+...+0x88 = 0xC3 + 0x264 -> 0x27
         send_byte(8'h27, 1'b0);
         chk("t6.cks.done8", 8'(pkt_done8), 8'h01);
         chk("t6.cks.err8",  8'(chk_err8),  8'h00);
      end
      @(posedge clk); #1;
      chk("t6.idle.write8", 8'(write8), 8'h00);
      chk("t6.idle.done8",  8'(pkt_done8), 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
